// File: rtl/satarx_responder.sv
// satarx_responder: receive-side link responder that answers the remote transmitter with SYNC/R_RDY/R_IP/HOLD/HOLDA/R_OK/R_ERR.
// Optional CRCW/STAT watchdog is compiled in when SATARX_RESPONDER_TIMEOUT_EN is defined.
module satarx_responder #(
  parameter logic OPT_LOWPOWER = 1'b0,
  parameter int   W            = 32,
  parameter int   TIMEOUT_W    = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_rx_valid,
  input  logic [W:0]   i_rx_data,
  input  logic         i_fifo_full,
  input  logic         i_crc_valid,
  input  logic         i_crc_ok,
  output logic         M_AXIS_TVALID,
  input  logic         M_AXIS_TREADY,
  output logic [W:0]   M_AXIS_TDATA,
  output logic         o_abort,
  output logic [2:0]   o_state
);

  localparam logic [W:0] P_SYNC  = {1'b1, W'(32'h7c95_b5b5)};
  localparam logic [W:0] P_X_RDY = {1'b1, W'(32'h7cb5_5757)};
  localparam logic [W:0] P_R_RDY = {1'b1, W'(32'h7c95_4a4a)};
  localparam logic [W:0] P_SOF   = {1'b1, W'(32'h7cb5_3737)};
  localparam logic [W:0] P_EOF   = {1'b1, W'(32'h7cb5_d5d5)};
  localparam logic [W:0] P_HOLD  = {1'b1, W'(32'h7caa_d5d5)};
  localparam logic [W:0] P_HOLDA = {1'b1, W'(32'h7caa_9595)};
  localparam logic [W:0] P_R_IP  = {1'b1, W'(32'h7cb5_5555)};
  localparam logic [W:0] P_R_OK  = {1'b1, W'(32'h7cb5_3535)};
  localparam logic [W:0] P_R_ERR = {1'b1, W'(32'h7cb5_5656)};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDY  = 3'd1,
    S_RCV  = 3'd2,
    S_CRCW = 3'd3,
    S_STAT = 3'd4
  } state_t;

  function automatic logic rx_is(input logic vld, input logic [W:0] word, input logic [W:0] code);
    return vld && (word == code);
  endfunction

  state_t     state;
  state_t     next_state;
  logic       crc_ok_q;
  logic       crc_ok_nxt;
  logic       hold_seen_q;
  logic       abort_nxt;
  logic       abort_q;
  logic       wdog_expired;
  logic [W:0] resp_sel;
  logic       vld_p1;
  logic [W:0] tdata_p1;

  // p0: primitive decode of the received word, straight from the PHY
  logic rx_sync_p0;
  logic rx_xrdy_p0;
  logic rx_sof_p0;
  logic rx_eof_p0;
  logic rx_hold_p0;

  assign rx_sync_p0 = rx_is(i_rx_valid, i_rx_data, P_SYNC);
  assign rx_xrdy_p0 = rx_is(i_rx_valid, i_rx_data, P_X_RDY);
  assign rx_sof_p0  = rx_is(i_rx_valid, i_rx_data, P_SOF);
  assign rx_eof_p0  = rx_is(i_rx_valid, i_rx_data, P_EOF);
  assign rx_hold_p0 = rx_is(i_rx_valid, i_rx_data, P_HOLD);

`ifdef SATARX_RESPONDER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q;

  assign wdog_expired = ((state == S_CRCW) || (state == S_STAT)) && (&wdog_q);

  // Restarts on every state entry so each wait phase gets a full window.
  always_ff @(posedge i_clk) begin
    if (i_reset || (next_state != state) || !((state == S_CRCW) || (state == S_STAT))) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      crc_ok_q    <= 1'b0;
      hold_seen_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state    <= next_state;
      crc_ok_q <= crc_ok_nxt;
      abort_q  <= abort_nxt;
      if (i_rx_valid) begin
        hold_seen_q <= rx_hold_p0;
      end
    end
  end

  always_comb begin
    next_state = state;
    crc_ok_nxt = crc_ok_q;
    abort_nxt  = 1'b0;
    resp_sel   = P_SYNC;
    case (state)
      S_IDLE: begin
        resp_sel = P_SYNC;
        if (rx_xrdy_p0) begin
          next_state = S_RDY;
        end
      end
      S_RDY: begin
        resp_sel = P_R_RDY;
        if (rx_sof_p0) begin
          next_state = S_RCV;
        end else if (rx_sync_p0) begin
          next_state = S_IDLE;
        end
      end
      S_RCV: begin
        // Local back-pressure wins over acknowledging the remote's HOLD.
        if (i_fifo_full) begin
          resp_sel = P_HOLD;
        end else if (hold_seen_q) begin
          resp_sel = P_HOLDA;
        end else begin
          resp_sel = P_R_IP;
        end
        if (rx_sync_p0) begin
          next_state = S_IDLE;
          abort_nxt  = 1'b1;
        end else if (rx_eof_p0) begin
          next_state = S_CRCW;
        end
      end
      S_CRCW: begin
        resp_sel = P_R_IP;
        if (rx_sync_p0) begin
          next_state = S_IDLE;
          abort_nxt  = 1'b1;
        end else if (i_crc_valid) begin
          crc_ok_nxt = i_crc_ok;
          next_state = S_STAT;
        end
      end
      S_STAT: begin
        resp_sel = crc_ok_q ? P_R_OK : P_R_ERR;
        if (rx_sync_p0) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    if (wdog_expired) begin
      next_state = S_IDLE;
      abort_nxt  = 1'b1;
    end
  end

  // p1: output register; a new primitive loads only when the PHY has taken the current one
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
    end else if (!vld_p1 || M_AXIS_TREADY) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= resp_sel;
    end
  end

  assign M_AXIS_TVALID = vld_p1;
  assign M_AXIS_TDATA  = (OPT_LOWPOWER && !vld_p1) ? '0 : tdata_p1;
  assign o_abort       = abort_q;
  assign o_state       = state;

endmodule

// File: tb/tb_satarx_responder.sv
// Directed bench for satarx_responder: rows push expected visible outputs, a negedge monitor pops and compares.
module tb_satarx_responder;
  localparam int W = 32;

  localparam logic [W:0] SYNC  = 33'h1_7c95_b5b5;
  localparam logic [W:0] X_RDY = 33'h1_7cb5_5757;
  localparam logic [W:0] R_RDY = 33'h1_7c95_4a4a;
  localparam logic [W:0] SOF   = 33'h1_7cb5_3737;
  localparam logic [W:0] EOF   = 33'h1_7cb5_d5d5;
  localparam logic [W:0] HOLD  = 33'h1_7caa_d5d5;
  localparam logic [W:0] HOLDA = 33'h1_7caa_9595;
  localparam logic [W:0] R_IP  = 33'h1_7cb5_5555;
  localparam logic [W:0] R_OK  = 33'h1_7cb5_3535;
  localparam logic [W:0] R_ERR = 33'h1_7cb5_5656;
  localparam logic [W:0] WTRM  = 33'h1_7cb5_5858;
  localparam logic [W:0] D1    = 33'h0_1234_5678;
  localparam logic [W:0] D2    = 33'h0_dead_beef;
  localparam logic [W:0] D3    = 33'h0_7c95_b5b5;
  localparam logic [W:0] NONE  = 33'h0;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_rx_valid;
  logic [W:0]   i_rx_data;
  logic         i_fifo_full;
  logic         i_crc_valid;
  logic         i_crc_ok;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY;
  logic [W:0]   M_AXIS_TDATA;
  logic         o_abort;
  logic [2:0]   o_state;

  always #5 clk = ~clk;

  satarx_responder #(.OPT_LOWPOWER(1'b0), .W(W), .TIMEOUT_W(16)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .i_fifo_full  (i_fifo_full),
    .i_crc_valid  (i_crc_valid),
    .i_crc_ok     (i_crc_ok),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .o_abort      (o_abort),
    .o_state      (o_state)
  );

  typedef struct packed {
    logic       vld;
    logic [W:0] tdata;
    logic [2:0] st;
    logic       ab;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   beat     = 0;
  logic mon_en   = 1'b0;
  logic done     = 1'b0;
  logic final_checked = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow beat%0d: got no expected entry, required one", beat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({M_AXIS_TVALID, M_AXIS_TDATA, o_state, o_abort} === e) begin
          n_pass++;
        end else begin
          $display("FAIL beat%0d: got vld=%b tdata=%h st=%0d abort=%b, required vld=%b tdata=%h st=%0d abort=%b",
                   beat, M_AXIS_TVALID, M_AXIS_TDATA, o_state, o_abort, e.vld, e.tdata, e.st, e.ab);
        end
      end
      beat++;
    end else if (done && !final_checked) begin
      final_checked = 1'b1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_leftover: got %0d unchecked entries, required 0", exp_q.size());
    end
  end

  // One cycle: expectations describe what is visible now; inputs are what is driven now.
  task automatic step(input logic ev, input logic [W:0] etd, input logic [2:0] est, input logic eab,
                      input logic v, input logic [W:0] d, input logic rdy = 1'b1, input logic ff = 1'b0,
                      input logic cv = 1'b0, input logic ck = 1'b0, input logic rst = 1'b0);
    exp_t e;
    e.vld = ev; e.tdata = etd; e.st = est; e.ab = eab;
    exp_q.push_back(e);
    i_reset = rst; i_rx_valid = v; i_rx_data = d; M_AXIS_TREADY = rdy;
    i_fifo_full = ff; i_crc_valid = cv; i_crc_ok = ck;
    @(posedge clk); #1;
  endtask

  initial begin
    i_reset = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0; i_fifo_full = 1'b0;
    i_crc_valid = 1'b0; i_crc_ok = 1'b0; M_AXIS_TREADY = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // T1: reset, then SYNC stream with data/unknown primitives ignored in IDLE
    step(0, NONE, 0, 0, 0, NONE, 1, 0, 0, 0, 1);
    step(0, NONE, 0, 0, 1, SYNC);
    step(1, SYNC, 0, 0, 1, SYNC);
    step(1, SYNC, 0, 0, 1, D1);
    step(1, SYNC, 0, 0, 1, HOLD);
    step(1, SYNC, 0, 0, 1, R_OK);
    step(1, SYNC, 0, 0, 0, NONE);

    // T2: good frame -> R_OK, SYNC returns to IDLE
    step(1, SYNC,  0, 0, 1, X_RDY);
    step(1, SYNC,  1, 0, 1, SOF);
    step(1, R_RDY, 2, 0, 1, D1);
    step(1, R_IP,  2, 0, 1, D2);
    step(1, R_IP,  2, 0, 1, D3);
    step(1, R_IP,  2, 0, 1, EOF);
    step(1, R_IP,  3, 0, 0, NONE, 1, 0, 1, 1);
    step(1, R_IP,  4, 0, 0, NONE);
    step(1, R_OK,  4, 0, 1, SYNC);
    step(1, R_OK,  0, 0, 1, SYNC);

    // T3: stray crc in RCV, crc lost with EOF, bad crc -> R_ERR held through WTRM/data
    step(1, SYNC,  0, 0, 1, X_RDY);
    step(1, SYNC,  1, 0, 1, SOF);
    step(1, R_RDY, 2, 0, 1, D1,   1, 0, 1, 1);
    step(1, R_IP,  2, 0, 1, EOF,  1, 0, 1, 1);
    step(1, R_IP,  3, 0, 0, NONE);
    step(1, R_IP,  3, 0, 0, NONE, 1, 0, 1, 0);
    step(1, R_IP,  4, 0, 1, WTRM);
    step(1, R_ERR, 4, 0, 0, NONE);
    step(1, R_ERR, 4, 0, 1, D2);
    step(1, R_ERR, 4, 0, 1, SYNC);
    step(1, R_ERR, 0, 0, 0, NONE);

    // T4: remote HOLD -> HOLDA; local fifo_full -> HOLD with priority
    step(1, SYNC,  0, 0, 1, X_RDY);
    step(1, SYNC,  1, 0, 1, SOF);
    step(1, R_RDY, 2, 0, 1, HOLD);
    step(1, R_IP,  2, 0, 1, HOLD);
    step(1, HOLDA, 2, 0, 1, HOLD);
    step(1, HOLDA, 2, 0, 1, HOLD, 1, 1);
    step(1, HOLD,  2, 0, 1, D1,   1, 1);
    step(1, HOLD,  2, 0, 1, D2);
    step(1, R_IP,  2, 0, 0, NONE);

    // T5: SYNC mid-frame aborts for exactly one cycle
    step(1, R_IP,  2, 0, 1, SYNC);
    step(1, R_IP,  0, 1, 0, NONE);

    // T6: TREADY low for 5 cycles across a state change
    step(1, SYNC,  0, 0, 1, X_RDY, 0);
    step(1, SYNC,  1, 0, 0, NONE,  0);
    step(1, SYNC,  1, 0, 0, NONE,  0);
    step(1, SYNC,  1, 0, 0, NONE,  0);
    step(1, SYNC,  1, 0, 0, NONE,  0);
    step(1, SYNC,  1, 0, 0, NONE,  1);
    step(1, R_RDY, 1, 0, 1, SYNC,  1);
    step(1, R_RDY, 0, 0, 0, NONE);

    // T7: reset mid-frame returns to IDLE without an abort pulse
    step(1, SYNC,  0, 0, 1, X_RDY);
    step(1, SYNC,  1, 0, 1, SOF);
    step(1, R_RDY, 2, 0, 1, D1);
    step(1, R_IP,  2, 0, 0, NONE, 1, 0, 0, 0, 1);
    step(0, NONE,  0, 0, 0, NONE, 1, 0, 0, 0, 1);
    step(0, NONE,  0, 0, 0, NONE);
    step(1, SYNC,  0, 0, 0, NONE);

    mon_en = 1'b0;
    done   = 1'b1;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
